// File: rtl/poly_pkg.sv
// poly_pkg: shared encodings, sizes and FSM state type for the poly unit
package poly_pkg;
  localparam logic [1:0] SEL_NTT = 2'd0;
  localparam logic [1:0] SEL_INTT = 2'd1;
  localparam logic [1:0] SEL_BYP = 2'd2;
  localparam logic [1:0] SEL_ILL = 2'd3;
  localparam int N = 256;
  localparam int KYBER_Q = 3329;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: combinational butterfly read addresses and twiddle index from (layer, i, mode)
module ntt_addr_gen import poly_pkg::*; #(
  parameter int LOGN = 8
) (
  input  logic [$clog2(LOGN)-1:0] layer,
  input  logic [LOGN-2:0]         i,
  input  logic [1:0]              sel,
  output logic [LOGN-1:0]         addr_a,
  output logic [LOGN-1:0]         addr_b,
  output logic [LOGN-2:0]         tw
);
  localparam int SW = $clog2(LOGN) + 1;
  localparam int IW = LOGN - 1;
  logic [SW-1:0] sh;
  logic [LOGN-1:0] len;
  logic [IW-1:0] g;
  // sh = log2(len); bypass runs with layer 0 so it shares the NTT layer-0 geometry
  always_comb begin
    sh = sel == SEL_INTT ? SW'(layer) + SW'(1) : SW'(LOGN - 1) - SW'(layer);
    len = LOGN'(1) << sh;
    g = i >> sh;
    addr_a = ({1'b0, g} << (sh + SW'(1))) | ({1'b0, i} & (len - LOGN'(1)));
    addr_b = addr_a + len;
    tw = sel == SEL_BYP ? '0 :
         sel == SEL_INTT ? (IW'(1) << (SW'(LOGN) - sh)) - IW'(1) - g :
         (IW'(1) << (SW'(LOGN - 1) - sh)) + g;
  end
endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: NTT/INTT/bypass sequencer for the butterfly unit; NTT_CTRL_PERF_EN adds a cyc_cnt job-length counter
module ntt_ctrl import poly_pkg::*; #(
  parameter int LOGN = 8,
  parameter int NLAYER = 7,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_addr,
  output logic [1:0]      bf_sel,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
`ifdef NTT_CTRL_PERF_EN
  ,
  output logic [15:0]     cyc_cnt
`endif
);
  localparam int D = RD_LAT + BF_LAT;
  localparam int LW = $clog2(LOGN);
  localparam int IW = LOGN - 1;
  localparam int DW = $clog2(D + 1);
  state_t state;
  logic [LW-1:0] layer, gl;
  logic [IW-1:0] idx, gi, gtw;
  logic [DW-1:0] dcnt;
  logic [1:0] gsel;
  logic [LOGN-1:0] ga, gb;
  logic acc, iss, last;
  logic [2*LOGN:0] dly [D];
  // the generator looks one cycle ahead so the read strobe and addresses leave registered
  always_comb begin
    acc = state == IDLE && start && mode != SEL_ILL;
    last = bf_sel == SEL_BYP || layer == LW'(NLAYER - 1);
    iss = acc || state == ISSUE || (state == DRAIN && dcnt == DW'(D) && !last);
    gsel = state == IDLE ? mode : bf_sel;
    gl = state == DRAIN ? layer + LW'(1) : layer;
    gi = state == ISSUE ? idx : '0;
  end
  ntt_addr_gen #(.LOGN(LOGN)) u_gen (
    .layer(gl), .i(gi), .sel(gsel), .addr_a(ga), .addr_b(gb), .tw(gtw)
  );
  // job FSM: issue 128 butterflies, drain the pipeline, repeat per layer, then pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      layer <= '0;
      idx <= '0;
      dcnt <= '0;
      bf_sel <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rd_en <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      rd_en <= iss;
      if (iss) begin
        rd_addr_a <= ga;
        rd_addr_b <= gb;
        tw_addr <= gtw;
      end
      case (state)
        IDLE: if (start) begin
          if (mode == SEL_ILL) err <= 1'b1;
          else begin
            bf_sel <= mode;
            layer <= '0;
            idx <= IW'(1);
            busy <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          idx <= idx + IW'(1);
          if (&idx) begin
            dcnt <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(D)) begin
            if (last) begin
              done <= 1'b1;
              state <= DONE;
            end else begin
              layer <= layer + LW'(1);
              idx <= IW'(1);
              state <= ISSUE;
            end
          end
        end
        default: begin
          busy <= 1'b0;
          layer <= '0;
          idx <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
  // write-back strobe and addresses trail the reads by the full read + butterfly latency
  always_ff @(posedge clk) begin
    if (rst) for (int k = 0; k < D; k++) dly[k] <= '0;
    else begin
      dly[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
    end
  end
  assign {wr_en, wr_addr_a, wr_addr_b} = dly[D-1];
`ifdef NTT_CTRL_PERF_EN
  // counts busy cycles of the current job and holds after done until the next accept
  always_ff @(posedge clk) begin
    if (rst || acc) cyc_cnt <= '0;
    else if (busy) cyc_cnt <= cyc_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: randomized job stream against a cycle-level behavioural model of ntt_ctrl
module tb_ntt_ctrl;
  localparam int D = 6;
  localparam int P = 128 + D;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic busy, done, err, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_addr;
  logic [1:0] bf_sel;
`ifdef NTT_CTRL_PERF_EN
  logic [15:0] cyc_cnt;
`endif
  int checks = 0, errors = 0;
  bit chk_on = 0;
  bit m_act = 0, m_err = 0;
  int m_t = 0, m_sel = 0, m_len = 1;
  int m_cnt = 0;
  bit er, ew;
  int ea, eb, et, xa, xb, xt;

  ntt_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_sel(bf_sel), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
`ifdef NTT_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d act=%0d exp=%0d", nm, m_t, act, exp);
    end
  endtask

  // what the read port must show at job cycle t, straight from the layer/len formulas
  function automatic void exp_at(input int sel, input int nl, input int t,
                                 output bit v, output int a, output int b, output int tw);
    int p, i, ln, g;
    v = 0; a = 0; b = 0; tw = 0;
    if (t < 1 || t > nl * P) return;
    p = (t - 1) / P;
    i = (t - 1) % P;
    if (i >= 128) return;
    v = 1;
    ln = sel == 1 ? (1 << (p + 1)) : (1 << (7 - p));
    g = i / ln;
    a = g * 2 * ln + i % ln;
    b = a + ln;
    tw = sel == 2 ? 0 : sel == 0 ? 128 / ln + g : 256 / ln - 1 - g;
  endfunction

  // model: job-relative cycle number, latched mode, error pulse and perf count
  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_err = 0; m_t = 0; m_sel = 0; m_cnt = 0;
    end else begin
      m_err = !m_act && start && mode == 2'd3;
      if (m_act) begin
        m_cnt++;
        m_t++;
        if (m_t > m_len * P + 1) m_act = 0;
      end else if (start && mode != 2'd3) begin
        m_act = 1; m_t = 1; m_sel = int'(mode); m_len = mode == 2'd2 ? 1 : 7; m_cnt = 0;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) if (chk_on) begin
    er = 0; ew = 0;
    if (m_act) begin
      exp_at(m_sel, m_len, m_t, er, ea, eb, et);
      exp_at(m_sel, m_len, m_t - D, ew, xa, xb, xt);
    end
    chk("busy", busy, m_act);
    chk("done", done, m_act && m_t == m_len * P + 1);
    chk("err", err, m_err);
    chk("bf_sel", bf_sel, m_sel);
    chk("rd_en", rd_en, er);
    chk("wr_en", wr_en, ew);
    if (er) begin
      chk("rd_addr_a", rd_addr_a, ea);
      chk("rd_addr_b", rd_addr_b, eb);
      chk("tw_addr", tw_addr, et);
    end
    if (ew) begin
      chk("wr_addr_a", wr_addr_a, xa);
      chk("wr_addr_b", wr_addr_b, xb);
    end
`ifdef NTT_CTRL_PERF_EN
    chk("cyc_cnt", cyc_cnt, m_cnt);
`endif
  end

  task automatic wait_idle();
    int n = 0;
    while (m_act && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (m_act) chk("idle_timeout", 1, 0);
  endtask

  task automatic go(input logic [1:0] m);
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_t(input int n);
    repeat (n - m_t) @(negedge clk);
  endtask

  task automatic lit(input string nm, input int a, input int b, input int tw);
    chk({nm, "_a"}, rd_addr_a, a);
    chk({nm, "_b"}, rd_addr_b, b);
    chk({nm, "_tw"}, tw_addr, tw);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_bf_sel", bf_sel, 0);
    rst = 1'b0;
    chk_on = 1;
    go(2'd0);
    lit("ntt_c1", 0, 128, 1);
    wait_t(7);
    chk("ntt_wr_first", wr_en, 1);
    chk("ntt_wr_a0", wr_addr_a, 0);
    wait_t(128);
    lit("ntt_c128", 127, 255, 1);
    wait_t(1 + P + 64);
    lit("ntt_l1_i64", 128, 192, 3);
    wait_t(1 + 6 * P);
    lit("ntt_l6_i0", 0, 2, 64);
    wait_t(2 + 6 * P);
    lit("ntt_l6_i1", 1, 3, 64);
    wait_t(3 + 6 * P);
    lit("ntt_l6_i2", 4, 6, 65);
    wait_t(939);
    chk("ntt_done939", done, 1);
    @(negedge clk);
    chk("ntt_busy_off", busy, 0);
`ifdef NTT_CTRL_PERF_EN
    chk("perf_939", cyc_cnt, 939);
    repeat (5) @(negedge clk);
    chk("perf_hold", cyc_cnt, 939);
`endif
    go(2'd1);
    lit("intt_l0_i0", 0, 2, 127);
    chk("intt_sel", bf_sel, 1);
    wait_t(1 + 6 * P);
    lit("intt_l6_i0", 0, 128, 1);
    wait_t(939);
    chk("intt_done939", done, 1);
    go(2'd2);
    chk("byp_sel", bf_sel, 2);
    wait_t(135);
    chk("byp_done135", done, 1);
    go(2'd3);
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    @(negedge clk);
    chk("ill_err_pulse", err, 0);
    go(2'd0);
    wait_t(300);
    start = 1'b1;
    mode = 2'd1;
    @(negedge clk);
    start = 1'b0;
    wait_t(939);
    chk("busy_start_done939", done, 1);
    go(2'd0);
    wait_t(500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_busy", busy, 0);
    go(2'd0);
    wait_t(939);
    chk("after_rst_done939", done, 1);
    for (int n = 0; n < 16; n++) begin
      go(2'($urandom_range(0, 3)));
      for (int c = 0; c < 1000 && m_act; c++) begin
        start = $urandom_range(0, 40) == 0;
        mode = 2'($urandom_range(0, 3));
        rst = $urandom_range(0, 3000) == 0;
        @(negedge clk);
      end
      start = 1'b0;
      rst = 1'b0;
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
